// File: rtl/if_stage_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
// Field positions locate the opcode and func fields within an instruction word.
package if_stage_pkg;

    typedef enum logic {
        IF_IDLE = 1'b0,
        IF_RUN  = 1'b1
    } if_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0;

    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 26;
    localparam int FUNC_HI = 5;
    localparam int FUNC_LO = 0;

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: holds the fetched instruction, its PC+1 and a valid flag.
// A flush inserts a NOP bubble and takes priority over hold.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         hold,
    input  logic         flush,
    input  logic         load,
    input  logic [N-1:0] instr_in,
    input  logic [N-1:0] pc_plus1_in,
    output logic [N-1:0] instr,
    output logic [N-1:0] pc_plus1,
    output logic         valid
);

    logic [N-1:0] instr_q, instr_d;
    logic [N-1:0] pc_plus1_q, pc_plus1_d;
    logic         valid_q, valid_d;

    always_comb begin
        instr_d    = instr_q;
        pc_plus1_d = pc_plus1_q;
        valid_d    = valid_q;
        if (flush) begin
            instr_d    = N'(NOP_INSTR);
            pc_plus1_d = '0;
            valid_d    = 1'b0;
        end else if (!hold && load) begin
            instr_d    = instr_in;
            pc_plus1_d = pc_plus1_in;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr_q    <= N'(NOP_INSTR);
            pc_plus1_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus1_q <= pc_plus1_d;
            valid_q    <= valid_d;
        end
    end

    assign instr    = instr_q;
    assign pc_plus1 = pc_plus1_q;
    assign valid    = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and the IDLE/RUN fetch state machine, drives the
// instruction memory read port and feeds the IF/ID register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int          N        = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         halt,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_target,
    output logic         imem_ren,
    output logic [N-1:0] imem_addr,
    input  logic [N-1:0] imem_dout,
    output logic [N-1:0] pc,
    output logic [N-1:0] if_id_instr,
    output logic [N-1:0] if_id_pc_plus1,
    output logic         if_id_valid,
    output logic [5:0]   opcode,
    output logic [5:0]   func,
    output logic [N-1:0] fetch_count
);

    if_state_e    state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    logic [N-1:0] fetch_count_q, fetch_count_d;
    logic [N-1:0] pc_plus1;
    logic         ifid_hold, ifid_flush, ifid_load;

    assign pc_plus1 = pc_q + 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IF_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // halt beats start in IDLE, so a simultaneous request leaves the block idle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IF_IDLE: if (start && !halt) state_d = IF_RUN;
            IF_RUN:  if (halt)           state_d = IF_IDLE;
            default:                     state_d = IF_IDLE;
        endcase
    end

    always_comb begin
        imem_ren   = 1'b0;
        ifid_hold  = 1'b1;
        ifid_flush = 1'b0;
        ifid_load  = 1'b0;
        if (state_q == IF_RUN) begin
            imem_ren = 1'b1;
            if (halt || branch_taken) begin
                ifid_flush = 1'b1;
            end else if (!stall) begin
                ifid_hold = 1'b0;
                ifid_load = 1'b1;
            end
        end
    end

    // A taken branch overrides stall: the stalled word is wrong-path anyway
    always_comb begin
        pc_d          = pc_q;
        fetch_count_d = fetch_count_q;
        if (state_q == IF_RUN && !halt) begin
            if (branch_taken) begin
                pc_d = branch_target;
            end else if (!stall) begin
                pc_d          = pc_plus1;
                fetch_count_d = fetch_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q          <= N'(RESET_PC);
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    if_id_reg #(
        .N(N)
    ) u_if_id_reg (
        .clock       (clock),
        .reset       (reset),
        .hold        (ifid_hold),
        .flush       (ifid_flush),
        .load        (ifid_load),
        .instr_in    (imem_dout),
        .pc_plus1_in (pc_plus1),
        .instr       (if_id_instr),
        .pc_plus1    (if_id_pc_plus1),
        .valid       (if_id_valid)
    );

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign fetch_count = fetch_count_q;
    assign opcode      = if_id_instr[OPC_HI:OPC_LO];
    assign func        = if_id_instr[FUNC_HI:FUNC_LO];

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage with a 1024-word combinational instruction memory.
module tb_if_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        start, halt, stall, branch_taken;
    logic [31:0] branch_target;
    logic        imem_ren;
    logic [31:0] imem_addr, imem_dout, pc;
    logic [31:0] if_id_instr, if_id_pc_plus1;
    logic        if_id_valid;
    logic [5:0]  opcode, func;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:1023];
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    assign imem_dout = mem[imem_addr[9:0]];

    if_stage #(.RESET_PC(32'd0), .N(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .halt           (halt),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_ren       (imem_ren),
        .imem_addr      (imem_addr),
        .imem_dout      (imem_dout),
        .pc             (pc),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus1 (if_id_pc_plus1),
        .if_id_valid    (if_id_valid),
        .opcode         (opcode),
        .func           (func),
        .fetch_count    (fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA5000000 | i;
        mem[0] = 32'h20080005;
        mem[1] = 32'h01095020;
        mem[2] = 32'hAC0A0004;

        reset = 1'b1; start = 1'b0; halt = 1'b0; stall = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0;
        #3;
        check("rst_pc", pc, 32'h0);
        check("rst_ren", {31'b0, imem_ren}, 32'h0);
        check("rst_valid", {31'b0, if_id_valid}, 32'h0);
        check("rst_instr", if_id_instr, 32'h0);
        check("rst_count", fetch_count, 32'h0);
        @(negedge clock) reset = 1'b0;

        // idle ignores branch and stall
        branch_taken = 1'b1; branch_target = 32'h55; stall = 1'b1;
        step();
        check("idle_pc", pc, 32'h0);
        check("idle_ren", {31'b0, imem_ren}, 32'h0);
        branch_taken = 1'b0; stall = 1'b0;

        start = 1'b1;
        step();
        start = 1'b0;
        check("start_ren", {31'b0, imem_ren}, 32'h1);
        check("start_addr", imem_addr, 32'h0);
        check("start_valid", {31'b0, if_id_valid}, 32'h0);

        step();
        check("f0_instr", if_id_instr, 32'h20080005);
        check("f0_opc", {26'b0, opcode}, 32'h08);
        check("f0_pp1", if_id_pc_plus1, 32'h1);
        check("f0_valid", {31'b0, if_id_valid}, 32'h1);
        step();
        check("f1_instr", if_id_instr, 32'h01095020);
        check("f1_opc", {26'b0, opcode}, 32'h00);
        check("f1_func", {26'b0, func}, 32'h20);
        step();
        check("f2_instr", if_id_instr, 32'hAC0A0004);
        check("f2_opc", {26'b0, opcode}, 32'h2B);
        check("f2_func", {26'b0, func}, 32'h04);
        check("f2_count", fetch_count, 32'd3);
        check("f2_pc", pc, 32'd3);

        step();
        step();
        check("pre_stall_pc", pc, 32'd5);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", pc, 32'd5);
            check("stall_instr", if_id_instr, 32'hA5000004);
            check("stall_count", fetch_count, 32'd5);
        end
        stall = 1'b0;
        step();
        check("unstall_pc", pc, 32'd6);
        check("unstall_instr", if_id_instr, 32'hA5000005);
        check("unstall_count", fetch_count, 32'd6);

        step();
        check("pre_br_pc", pc, 32'd7);
        branch_taken = 1'b1; branch_target = 32'h40;
        step();
        branch_taken = 1'b0;
        check("br_pc", pc, 32'h40);
        check("br_valid", {31'b0, if_id_valid}, 32'h0);
        check("br_instr", if_id_instr, 32'h0);
        check("br_count", fetch_count, 32'd7);
        step();
        check("br_tgt_instr", if_id_instr, 32'hA5000040);
        check("br_tgt_pp1", if_id_pc_plus1, 32'h41);
        check("br_tgt_valid", {31'b0, if_id_valid}, 32'h1);

        branch_taken = 1'b1; stall = 1'b1; branch_target = 32'h100;
        step();
        branch_taken = 1'b0; stall = 1'b0;
        check("brst_pc", pc, 32'h100);
        check("brst_valid", {31'b0, if_id_valid}, 32'h0);
        check("brst_count", fetch_count, 32'd8);
        step();
        check("brst_instr", if_id_instr, 32'hA5000100);
        check("brst_pp1", if_id_pc_plus1, 32'h101);
        check("brst_count2", fetch_count, 32'd9);

        branch_taken = 1'b1; branch_target = 32'h8;
        step();
        branch_taken = 1'b0;
        step();
        check("pre_rst_pc", pc, 32'd9);
        check("pre_rst_opc", {26'b0, opcode}, 32'h29);
        #2 reset = 1'b1;
        #1;
        check("mrst_pc", pc, 32'h0);
        check("mrst_ren", {31'b0, imem_ren}, 32'h0);
        check("mrst_instr", if_id_instr, 32'h0);
        check("mrst_opc", {26'b0, opcode}, 32'h0);
        check("mrst_pp1", if_id_pc_plus1, 32'h0);
        check("mrst_count", fetch_count, 32'h0);
        @(negedge clock) reset = 1'b0;
        step();
        check("post_rst_ren", {31'b0, imem_ren}, 32'h0);
        check("post_rst_pc", pc, 32'h0);

        start = 1'b1;
        step();
        start = 1'b0;
        branch_taken = 1'b1; branch_target = 32'hFFFFFFFF;
        step();
        branch_taken = 1'b0;
        check("wrap_pre_pc", pc, 32'hFFFFFFFF);
        check("wrap_alias_addr", imem_addr, 32'hFFFFFFFF);
        step();
        check("wrap_pc", pc, 32'h0);
        check("wrap_instr", if_id_instr, 32'hA50003FF);
        check("wrap_pp1", if_id_pc_plus1, 32'h0);
        check("wrap_count", fetch_count, 32'd1);

        halt = 1'b1;
        step();
        check("halt_ren", {31'b0, imem_ren}, 32'h0);
        check("halt_valid", {31'b0, if_id_valid}, 32'h0);
        check("halt_pc", pc, 32'h0);
        start = 1'b1;
        step();
        step();
        check("hs_ren", {31'b0, imem_ren}, 32'h0);
        check("hs_pc", pc, 32'h0);
        check("hs_count", fetch_count, 32'd1);
        halt = 1'b0; start = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
